// File: rtl/seq_alu.sv
// Sequential ALU with a valid/ready request and result handshake.
// Single-cycle ops finish in one cycle; multu and divu run a one-bit-per-cycle loop.
module seq_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  input  logic [2:0]       alucontrol,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi,
  output logic             zero,
  output logic             ovf,
  output logic             err
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;
  typedef enum logic [2:0] {
    OP_ADD   = 3'b000,
    OP_SUB   = 3'b001,
    OP_AND   = 3'b010,
    OP_MULTU = 3'b011,
    OP_DIVU  = 3'b100,
    OP_ILL   = 3'b101,
    OP_OR    = 3'b110,
    OP_SLT   = 3'b111
  } op_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic            is_div_q, is_div_d;
  logic            zero_q, zero_d;
  logic            ovf_q, ovf_d;
  logic            err_q, err_d;
  logic            accept;

  // {hi,lo} doubles as the iteration register: product/multiplier or remainder/quotient.
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_hi, mul_lo;
  logic [WIDTH:0]   div_rem;
  logic [WIDTH-1:0] div_diff, div_hi, div_lo;
  logic             div_ge;
  logic [WIDTH-1:0] sum, diff;

  assign mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
  assign mul_hi   = mul_sum[WIDTH:1];
  assign mul_lo   = {mul_sum[0], lo_q[WIDTH-1:1]};

  // Remainder stays below the divisor, so the trial difference fits in WIDTH bits.
  assign div_rem  = {hi_q, lo_q[WIDTH-1]};
  assign div_ge   = div_rem >= {1'b0, b_q};
  assign div_diff = div_rem[WIDTH-1:0] - b_q;
  assign div_hi   = div_ge ? div_diff : div_rem[WIDTH-1:0];
  assign div_lo   = {lo_q[WIDTH-2:0], div_ge};

  assign sum  = srca + srcb;
  assign diff = srca - srcb;

  always_comb begin
    // NOTE: every comb output gets a default first so no path infers a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    b_d      = b_q;
    lo_d     = lo_q;
    hi_d     = hi_q;
    is_div_d = is_div_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
    err_d    = err_q;
    in_ready = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    accept   = in_valid && in_ready;

    case (state_q)
      BUSY: begin
        lo_d = is_div_q ? div_lo : mul_lo;
        hi_d = is_div_q ? div_hi : mul_hi;
        if (cnt_q == '0) state_d = DONE;
        else             cnt_d   = cnt_q - CW'(1);
      end
      DONE:    if (out_ready) state_d = IDLE;
      default: ;
    endcase

    // Acceptance in DONE overrides the retire-to-IDLE decision above.
    if (accept) begin
      state_d = DONE;
      hi_d    = '0;
      ovf_d   = 1'b0;
      err_d   = 1'b0;
      case (op_e'(alucontrol))
        OP_ADD: begin
          lo_d  = sum;
          ovf_d = (srca[WIDTH-1] == srcb[WIDTH-1]) && (sum[WIDTH-1] != srca[WIDTH-1]);
        end
        OP_SUB: begin
          lo_d  = diff;
          ovf_d = (srca[WIDTH-1] != srcb[WIDTH-1]) && (diff[WIDTH-1] != srca[WIDTH-1]);
        end
        OP_AND: lo_d = srca & srcb;
        OP_OR:  lo_d = srca | srcb;
        OP_SLT: lo_d = {{(WIDTH-1){1'b0}}, ($signed(srca) < $signed(srcb))};
        OP_MULTU: begin
          lo_d     = srca;
          b_d      = srcb;
          cnt_d    = CW'(WIDTH - 1);
          is_div_d = 1'b0;
          state_d  = BUSY;
        end
        OP_DIVU: begin
          if (srcb == '0) begin
            lo_d  = '1;
            hi_d  = srca;
            err_d = 1'b1;
          end else begin
            lo_d     = srca;
            b_d      = srcb;
            cnt_d    = CW'(WIDTH - 1);
            is_div_d = 1'b1;
            state_d  = BUSY;
          end
        end
        default: begin
          lo_d  = '0;
          err_d = 1'b1;
        end
      endcase
    end

    if (state_d == DONE) zero_d = (lo_d == '0);
  end

  // NOTE: sequential state uses non-blocking assignments only; every register,
  // datapath included, is cleared by reset because abort must leave no result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      b_q      <= '0;
      lo_q     <= '0;
      hi_q     <= '0;
      is_div_q <= 1'b0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      b_q      <= b_d;
      lo_q     <= lo_d;
      hi_q     <= hi_d;
      is_div_q <= is_div_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
      err_q    <= err_d;
    end
  end

  assign out_valid = (state_q == DONE);
  assign lo        = lo_q;
  assign hi        = hi_q;
  assign zero      = zero_q;
  assign ovf       = ovf_q;
  assign err       = err_q;

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu: directed corner cases, then randomized traffic,
// all compared cycle by cycle against an arithmetic reference model.
module tb_seq_alu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] srca = '0;
  logic [31:0] srcb = '0;
  logic [2:0]  alucontrol = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] lo, hi;
  logic        zero, ovf, err;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit rand_ready = 1'b0;

  typedef struct {
    logic [31:0] lo;
    logic [31:0] hi;
    logic        zero;
    logic        ovf;
    logic        err;
    int          lat;
    int          acc;
  } exp_t;

  exp_t q[$];

  seq_alu #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .srca(srca), .srcb(srcb), .alucontrol(alucontrol),
    .out_valid(out_valid), .out_ready(out_ready),
    .lo(lo), .hi(hi), .zero(zero), .ovf(ovf), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #5ms;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: what each opcode must produce, from plain integer arithmetic.
  function automatic exp_t model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    longint s;
    longint unsigned p;
    e.lo = '0; e.hi = '0; e.ovf = 1'b0; e.err = 1'b0; e.lat = 1; e.acc = 0;
    case (op)
      3'b000: begin
        e.lo = a + b;
        s = longint'($signed(a)) + longint'($signed(b));
        e.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      3'b001: begin
        e.lo = a - b;
        s = longint'($signed(a)) - longint'($signed(b));
        e.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      3'b010: e.lo = a & b;
      3'b110: e.lo = a | b;
      3'b111: e.lo = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'b011: begin
        p = longint'(a) * longint'(b);
        e.lo = p[31:0];
        e.hi = p[63:32];
        e.lat = 33;
      end
      3'b100: begin
        if (b == 0) begin
          e.lo = 32'hFFFF_FFFF; e.hi = a; e.err = 1'b1;
        end else begin
          e.lo = a / b; e.hi = a % b; e.lat = 33;
        end
      end
      default: e.err = 1'b1;
    endcase
    e.zero = (e.lo == 0);
    return e;
  endfunction

  // Compare process: expected valid/ready/result every cycle out of reset.
  always @(negedge clk) begin
    bit   ev, er;
    exp_t n;
    if (!rst_n) begin
      q.delete();
    end else begin
      ev = (q.size() > 0) && (cyc - q[0].acc >= q[0].lat);
      er = (q.size() == 0) || (ev && out_ready);
      check("out_valid", 64'(out_valid), 64'(ev));
      check("in_ready", 64'(in_ready), 64'(er));
      if (ev) begin
        check("lo", 64'(lo), 64'(q[0].lo));
        check("hi", 64'(hi), 64'(q[0].hi));
        check("zero", 64'(zero), 64'(q[0].zero));
        check("ovf", 64'(ovf), 64'(q[0].ovf));
        check("err", 64'(err), 64'(q[0].err));
        if (out_ready) void'(q.pop_front());
      end
      if (in_valid && er) begin
        n = model(alucontrol, srca, srcb);
        n.acc = cyc;
        q.push_back(n);
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bit ok = 1'b0;
    in_valid = 1'b1; alucontrol = op; srca = a; srcb = b;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    if (!ok) begin
      checks++; failures++;
      $display("FAIL accept_timeout actual=not_accepted required=accepted");
    end
    @(posedge clk); #1;
    in_valid = 1'b0; srca = $urandom; srcb = $urandom; alucontrol = 3'($urandom);
  endtask

  task automatic drain();
    for (int i = 0; i < 500 && q.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    if (q.size() != 0) begin
      checks++; failures++;
      $display("FAIL drain_timeout actual=%0d required=0", q.size());
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h7FFF_FFFF;
      4: return 32'h8000_0000;
      5: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    exp_t e;

    // Pin the model itself with hand-computed results.
    e = model(3'b000, 32'h7FFF_FFFF, 32'h1);
    check("pin_add_lo", 64'(e.lo), 64'h8000_0000);
    check("pin_add_ovf", 64'(e.ovf), 64'h1);
    e = model(3'b111, 32'hFFFF_FFFF, 32'h1);
    check("pin_slt_lo", 64'(e.lo), 64'h1);
    e = model(3'b001, 32'd5, 32'd5);
    check("pin_sub_zero", 64'(e.zero), 64'h1);
    e = model(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("pin_mul", {e.hi, e.lo}, 64'hFFFF_FFFE_0000_0001);
    check("pin_mul_lat", 64'(e.lat), 64'd33);
    e = model(3'b100, 32'd100, 32'd7);
    check("pin_div", {e.hi, e.lo}, {32'd2, 32'd14});
    e = model(3'b100, 32'd9, 32'd0);
    check("pin_div0", {e.hi, e.lo}, {32'd9, 32'hFFFF_FFFF});
    check("pin_div0_lat", 64'(e.lat), 64'd1);
    e = model(3'b101, 32'd3, 32'd4);
    check("pin_ill", {61'(e.lo), e.zero, e.err, e.ovf}, {61'd0, 1'b1, 1'b1, 1'b0});

    #1;
    check("rst_out_valid", 64'(out_valid), 64'h0);
    check("rst_lo_hi", {hi, lo}, 64'h0);
    check("rst_flags", 64'({zero, ovf, err}), 64'h0);
    #22 rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed corners.
    send(3'b000, 32'h7FFF_FFFF, 32'h1);
    send(3'b111, 32'hFFFF_FFFF, 32'h1);
    send(3'b001, 32'd5, 32'd5);
    send(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    send(3'b000, 32'd1, 32'd2);           // held high through the multu BUSY window
    send(3'b100, 32'd100, 32'd7);
    send(3'b100, 32'd9, 32'd0);
    send(3'b101, 32'd3, 32'd4);
    drain();

    // Hold the result in DONE, then retire it while accepting a new add.
    out_ready = 1'b0;
    send(3'b000, 32'd3, 32'd4);
    repeat (5) begin @(posedge clk); #1; end
    out_ready = 1'b1;
    send(3'b000, 32'd10, 32'd20);
    drain();

    // Abort a multu ten cycles into BUSY.
    send(3'b011, 32'h1234_5678, 32'h9ABC_DEF0);
    repeat (9) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("abort_out_valid", 64'(out_valid), 64'h0);
    check("abort_lo_hi", {hi, lo}, 64'h0);
    check("abort_flags", 64'({zero, ovf, err}), 64'h0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (40) begin @(posedge clk); #1; end
    check("post_abort_in_ready", 64'(in_ready), 64'h1);
    check("post_abort_out_valid", 64'(out_valid), 64'h0);

    // Randomized traffic with random back-pressure.
    rand_ready = 1'b1;
    for (int k = 0; k < 300; k++) begin
      send(3'($urandom), pick(), pick());
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
    rand_ready = 1'b0;
    @(posedge clk); #2;
    out_ready = 1'b1;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width in bits (legal range 8..64, even).
REQ-002 clk  input  1  rising-edge clock; all state updates on posedge clk.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  operation request valid.
REQ-005 in_ready  output  1  block can accept a request this cycle.
REQ-006 srca  input  WIDTH  operand A.
REQ-007 srcb  input  WIDTH  operand B.
REQ-008 alucontrol  input  3  opcode: 000 add, 001 sub, 010 and, 110 or, 111 slt (signed), 011 multu, 100 divu, 101 illegal.
REQ-009 out_valid  output  1  result valid.
REQ-010 out_ready  input  1  consumer accepts result.
REQ-011 lo  output  WIDTH  primary result; multu low half; divu quotient.
REQ-012 hi  output  WIDTH  multu high half; divu remainder; 0 for all other ops.
REQ-013 zero  output  1  lo == 0.
REQ-014 ovf  output  1  signed overflow of add/sub; 0 otherwise.
REQ-015 err  output  1  illegal opcode (101) or divu with srcb == 0.

Function
REQ-016 States SHALL be IDLE, BUSY, DONE.
REQ-017 in_ready SHALL be 1 in IDLE, and in DONE while out_ready is 1; 0 in BUSY.
REQ-018 Request accepted on cycle with in_valid && in_ready; operands and opcode SHALL be registered at that edge and ignored afterwards.
REQ-019 add/sub/and/or/slt/illegal SHALL go straight to DONE; out_valid asserted the cycle after acceptance (latency 1).
REQ-020 add/sub SHALL wrap modulo 2^WIDTH; ovf set when operand signs agree (add) or differ (sub) and result sign differs from srca.
REQ-021 slt SHALL yield lo = 1 if signed srca < signed srcb else 0.
REQ-022 Illegal opcode SHALL yield lo = 0, hi = 0, err = 1, zero = 1.
REQ-023 multu SHALL be unsigned shift-add, one bit per cycle: BUSY for exactly WIDTH cycles, out_valid asserted WIDTH+1 cycles after acceptance; {hi,lo} = srca*srcb.
REQ-024 divu SHALL be unsigned restoring division, one bit per cycle, same latency as multu; lo = quotient, hi = remainder.
REQ-025 divu with srcb == 0 SHALL skip BUSY: latency 1, lo = all ones, hi = srca, err = 1.
REQ-026 An internal iteration counter of clog2(WIDTH)+1 bits SHALL count WIDTH-1 down to 0; BUSY->DONE when counter reaches 0.
REQ-027 In DONE, lo/hi/zero/ovf/err and out_valid SHALL hold stable until out_ready is 1.
REQ-028 DONE with out_ready && !in_valid SHALL go to IDLE with out_valid deasserted next cycle.
REQ-029 DONE with out_ready && in_valid SHALL retire the current result and accept the new request on the same edge (back-to-back, no bubble for latency-1 ops).
REQ-030 in_valid during BUSY SHALL be ignored (no acceptance, no state change).
REQ-031 Result outputs SHALL be registered; no combinational path from srca/srcb to lo/hi.

Reset
REQ-032 rst_n low SHALL immediately force IDLE, out_valid = 0, lo = 0, hi = 0, zero = 0, ovf = 0, err = 0, counter = 0.
REQ-033 Reset during BUSY or DONE SHALL abort the operation; no result is produced after release.
REQ-034 First acceptance possible on the first rising edge with rst_n high; in_ready = 1 from that point.

Verification (WIDTH = 32)
REQ-035 add 0x7FFFFFFF + 1, out_ready = 1 -> next cycle out_valid = 1, lo = 0x80000000, ovf = 1, zero = 0, err = 0.
REQ-036 slt srca = 0xFFFFFFFF, srcb = 1 -> lo = 1; sub 5 - 5 -> lo = 0, zero = 1, ovf = 0.
REQ-037 multu 0xFFFFFFFF * 0xFFFFFFFF -> out_valid exactly 33 cycles after acceptance, hi = 0xFFFFFFFE, lo = 0x00000001; in_ready = 0 throughout BUSY, mid-BUSY in_valid ignored.
REQ-038 divu 100 / 7 -> latency 33, lo = 14, hi = 2; divu 9 / 0 -> latency 1, lo = 0xFFFFFFFF, hi = 9, err = 1.
REQ-039 Hold out_ready = 0 for 5 cycles in DONE -> outputs unchanged, in_ready = 0; then out_ready = 1 with new add request -> result retired and new add accepted same edge, its result valid next cycle.
REQ-040 Assert rst_n = 0 asynchronously at BUSY cycle 10 of a multu -> out_valid = 0, all outputs 0 immediately; after release no stale result appears, in_ready = 1.
